// File: rtl/hazard3_ahbl_arb_pkg.sv
// Shared constants and helpers for the AHB-Lite arbiter.
// Bus encodings come from the common Hazard3 header.
package hazard3_ahbl_arb_pkg;

`include "hazard3_ahb_defs.vh"

   localparam int unsigned MAX_PORTS = 8;

   function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         if (oh[i]) begin
            idx = idx | 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/hazard3_ahb_defs.vh
// Shared AHB-Lite encodings used across Hazard3 bus blocks.
// Included inside a package so every importer sees one definition.
`ifndef HAZARD3_AHB_DEFS_VH
`define HAZARD3_AHB_DEFS_VH

localparam logic [1:0] HTRANS_IDLE   = 2'b00;
localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
localparam logic [2:0] HBURST_SINGLE = 3'b000;
localparam logic [3:0] HPROT_DATA    = 4'b0011;
localparam logic [3:0] HPROT_INSTR   = 4'b0010;

`endif

// File: rtl/hazard3_onehot_rr_select.sv
// One-hot select of the first request at or above a pointer, wrapping to index 0.
// A pointer of zero degenerates to fixed lowest-index priority.
module hazard3_onehot_rr_select #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned W_PTR = 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [W_PTR-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt
);

   logic [N_REQ-1:0] w_mask;
   logic [N_REQ-1:0] w_req_hi;
   logic [N_REQ-1:0] w_gnt_hi;
   logic [N_REQ-1:0] w_gnt_lo;

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_mask[i] = (i >= 32'(i_ptr));
      end
   end

   assign w_req_hi = i_req & w_mask;

   // Descending scan leaves the lowest set bit as the survivor.
   always_comb begin
      w_gnt_hi = '0;
      w_gnt_lo = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (w_req_hi[i]) begin
            w_gnt_hi    = '0;
            w_gnt_hi[i] = 1'b1;
         end
         if (i_req[i]) begin
            w_gnt_lo    = '0;
            w_gnt_lo[i] = 1'b1;
         end
      end
   end

   assign o_gnt = (|w_req_hi) ? w_gnt_hi : w_gnt_lo;

endmodule

// File: rtl/hazard3_ahbl_arb.sv
// N-source AHB-Lite arbiter: panic-first, then rotating or fixed priority.
// Grant is frozen while an issued address phase is stalled by the slave.
module hazard3_ahbl_arb
   import hazard3_ahbl_arb_pkg::*;
#(
   parameter int unsigned N_PORTS     = 2,
   parameter int unsigned W_ADDR      = 32,
   parameter int unsigned W_DATA      = 32,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic [N_PORTS-1:0]          src_aph_req,
   input  logic [N_PORTS-1:0]          src_aph_panic,
   input  logic [N_PORTS-1:0]          src_aph_excl,
   input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
   input  logic [N_PORTS*3-1:0]        src_hsize,
   input  logic [N_PORTS-1:0]          src_hwrite,
   input  logic [N_PORTS*4-1:0]        src_hprot,
   input  logic [N_PORTS*W_DATA-1:0]   src_wdata,
   output logic [N_PORTS-1:0]          src_aph_ready,
   output logic [N_PORTS-1:0]          src_dph_ready,
   output logic [N_PORTS-1:0]          src_dph_err,
   output logic [N_PORTS-1:0]          src_dph_exokay,
   output logic [W_DATA-1:0]           src_rdata,

   output logic [W_ADDR-1:0]           ahblm_haddr,
   output logic                        ahblm_hwrite,
   output logic [1:0]                  ahblm_htrans,
   output logic [2:0]                  ahblm_hsize,
   output logic [2:0]                  ahblm_hburst,
   output logic [3:0]                  ahblm_hprot,
   output logic                        ahblm_hmastlock,
   output logic                        ahblm_hexcl,
   output logic [W_DATA-1:0]           ahblm_hwdata,
   input  logic                        ahblm_hready,
   input  logic                        ahblm_hresp,
   input  logic                        ahblm_hexokay,
   input  logic [W_DATA-1:0]           ahblm_hrdata
);

   localparam int unsigned W_PTR = $clog2(N_PORTS);

   logic                   r_hold_aph;
   logic [N_PORTS-1:0]     r_gnt_prev;
   logic [N_PORTS-1:0]     r_dph_owner;
   logic [W_PTR-1:0]       r_rr_ptr;

   logic [W_PTR-1:0]       w_sel_ptr;
   logic [N_PORTS-1:0]     w_gnt_panic;
   logic [N_PORTS-1:0]     w_gnt_req;
   logic [N_PORTS-1:0]     w_gnt;
   logic [MAX_PORTS-1:0]   w_gnt_ext;
   logic [2:0]             w_gnt_idx;
   logic [W_PTR-1:0]       w_ptr_nxt;

   assign w_sel_ptr = (ROUND_ROBIN != 0) ? r_rr_ptr : '0;

   hazard3_onehot_rr_select #(
      .N_REQ (N_PORTS),
      .W_PTR (W_PTR)
   ) u_sel_panic (
      .i_req (src_aph_panic),
      .i_ptr ('0),
      .o_gnt (w_gnt_panic)
   );

   hazard3_onehot_rr_select #(
      .N_REQ (N_PORTS),
      .W_PTR (W_PTR)
   ) u_sel_req (
      .i_req (src_aph_req),
      .i_ptr (w_sel_ptr),
      .o_gnt (w_gnt_req)
   );

   // A stalled address phase must not be withdrawn, even if the requester drops out.
   always_comb begin
      if (r_hold_aph) begin
         w_gnt = r_gnt_prev;
      end else if (|src_aph_panic) begin
         w_gnt = w_gnt_panic;
      end else begin
         w_gnt = w_gnt_req;
      end
   end

   always_comb begin
      w_gnt_ext = '0;
      w_gnt_ext[N_PORTS-1:0] = w_gnt;
   end

   assign w_gnt_idx = onehot_to_idx(w_gnt_ext);
   assign w_ptr_nxt = (32'(w_gnt_idx) == N_PORTS - 1) ? '0 : W_PTR'(32'(w_gnt_idx) + 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_aph  <= 1'b0;
         r_gnt_prev  <= '0;
         r_dph_owner <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_hold_aph <= ahblm_htrans[1] && !ahblm_hready;
         r_gnt_prev <= w_gnt;
         if (ahblm_hready) begin
            r_dph_owner <= w_gnt;
         end
         if ((ROUND_ROBIN != 0) && ahblm_hready && (|w_gnt)) begin
            r_rr_ptr <= w_ptr_nxt;
         end
      end
   end

   // AND-OR muxes: grant and owner are one-hot or zero, so a zero select yields zero.
   always_comb begin
      ahblm_haddr  = '0;
      ahblm_hsize  = '0;
      ahblm_hwrite = 1'b0;
      ahblm_hprot  = '0;
      ahblm_hexcl  = 1'b0;
      ahblm_hwdata = '0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         if (w_gnt[k]) begin
            ahblm_haddr  = ahblm_haddr  | src_haddr[k*W_ADDR +: W_ADDR];
            ahblm_hsize  = ahblm_hsize  | src_hsize[k*3 +: 3];
            ahblm_hwrite = ahblm_hwrite | src_hwrite[k];
            ahblm_hprot  = ahblm_hprot  | src_hprot[k*4 +: 4];
            ahblm_hexcl  = ahblm_hexcl  | src_aph_excl[k];
         end
         if (r_dph_owner[k]) begin
            ahblm_hwdata = ahblm_hwdata | src_wdata[k*W_DATA +: W_DATA];
         end
      end
   end

   assign ahblm_htrans    = (|w_gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
   assign ahblm_hburst    = HBURST_SINGLE;
   assign ahblm_hmastlock = 1'b0;

   assign src_aph_ready  = {N_PORTS{ahblm_hready}} & w_gnt;
   assign src_dph_ready  = {N_PORTS{ahblm_hready}} & r_dph_owner;
   assign src_dph_err    = {N_PORTS{ahblm_hresp}} & r_dph_owner;
   assign src_dph_exokay = {N_PORTS{ahblm_hexokay}} & r_dph_owner;
   assign src_rdata      = ahblm_hrdata;

endmodule

// File: tb/tb_hazard3_ahbl_arb.sv
// Scoreboard bench for hazard3_ahbl_arb: a 3-port rotating instance and a 3-port fixed instance
// share stimulus; expectations are queued per cycle and checked on the falling edge.
module tb_hazard3_ahbl_arb;

   localparam int unsigned NP = 3;
   localparam int unsigned WA = 32;
   localparam int unsigned WD = 32;

   logic             clk;
   logic             rst_n;
   logic [NP-1:0]    req, panic, excl, hwrite;
   logic [NP*WA-1:0] haddr;
   logic [NP*3-1:0]  hsize;
   logic [NP*4-1:0]  hprot;
   logic [NP*WD-1:0] wdata;
   logic             hready, hresp, hexokay;
   logic [WD-1:0]    hrdata;

   logic [NP-1:0]    aph_rdy, dph_rdy, dph_err, dph_exok;
   logic [WD-1:0]    rdata;
   logic [WA-1:0]    m_haddr;
   logic             m_hwrite, m_hmastlock, m_hexcl;
   logic [1:0]       m_htrans;
   logic [2:0]       m_hsize, m_hburst;
   logic [3:0]       m_hprot;
   logic [WD-1:0]    m_hwdata;

   logic [NP-1:0]    fx_aph_rdy, fx_dph_rdy, fx_dph_err, fx_dph_exok;
   logic [WD-1:0]    fx_rdata;
   logic [WA-1:0]    fx_haddr;
   logic             fx_hwrite, fx_hmastlock, fx_hexcl;
   logic [1:0]       fx_htrans;
   logic [2:0]       fx_hsize, fx_hburst;
   logic [3:0]       fx_hprot;
   logic [WD-1:0]    fx_hwdata;

   hazard3_ahbl_arb #(
      .N_PORTS (NP), .W_ADDR (WA), .W_DATA (WD), .ROUND_ROBIN (1)
   ) u_dut (
      .clk (clk), .rst_n (rst_n),
      .src_aph_req (req), .src_aph_panic (panic), .src_aph_excl (excl),
      .src_haddr (haddr), .src_hsize (hsize), .src_hwrite (hwrite), .src_hprot (hprot),
      .src_wdata (wdata),
      .src_aph_ready (aph_rdy), .src_dph_ready (dph_rdy), .src_dph_err (dph_err),
      .src_dph_exokay (dph_exok), .src_rdata (rdata),
      .ahblm_haddr (m_haddr), .ahblm_hwrite (m_hwrite), .ahblm_htrans (m_htrans),
      .ahblm_hsize (m_hsize), .ahblm_hburst (m_hburst), .ahblm_hprot (m_hprot),
      .ahblm_hmastlock (m_hmastlock), .ahblm_hexcl (m_hexcl), .ahblm_hwdata (m_hwdata),
      .ahblm_hready (hready), .ahblm_hresp (hresp), .ahblm_hexokay (hexokay),
      .ahblm_hrdata (hrdata)
   );

   hazard3_ahbl_arb #(
      .N_PORTS (NP), .W_ADDR (WA), .W_DATA (WD), .ROUND_ROBIN (0)
   ) u_dut_fx (
      .clk (clk), .rst_n (rst_n),
      .src_aph_req (req), .src_aph_panic (panic), .src_aph_excl (excl),
      .src_haddr (haddr), .src_hsize (hsize), .src_hwrite (hwrite), .src_hprot (hprot),
      .src_wdata (wdata),
      .src_aph_ready (fx_aph_rdy), .src_dph_ready (fx_dph_rdy), .src_dph_err (fx_dph_err),
      .src_dph_exokay (fx_dph_exok), .src_rdata (fx_rdata),
      .ahblm_haddr (fx_haddr), .ahblm_hwrite (fx_hwrite), .ahblm_htrans (fx_htrans),
      .ahblm_hsize (fx_hsize), .ahblm_hburst (fx_hburst), .ahblm_hprot (fx_hprot),
      .ahblm_hmastlock (fx_hmastlock), .ahblm_hexcl (fx_hexcl), .ahblm_hwdata (fx_hwdata),
      .ahblm_hready (hready), .ahblm_hresp (hresp), .ahblm_hexokay (hexokay),
      .ahblm_hrdata (hrdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {KAph, KDph, KErr, KExok, KTrans, KAddr, KWdata, KWrite, KFxAph} kind_e;

   string       tag_q[$];
   kind_e       kind_q[$];
   logic [31:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input kind_e k, input logic [31:0] v);
      tag_q.push_back(tag);
      kind_q.push_back(k);
      exp_q.push_back(v);
   endtask

   function automatic logic [31:0] observe(input kind_e k);
      case (k)
         KAph:    return 32'(aph_rdy);
         KDph:    return 32'(dph_rdy);
         KErr:    return 32'(dph_err);
         KExok:   return 32'(dph_exok);
         KTrans:  return 32'(m_htrans);
         KAddr:   return m_haddr;
         KWdata:  return m_hwdata;
         KWrite:  return 32'(m_hwrite);
         KFxAph:  return 32'(fx_aph_rdy);
         default: return 32'hdead_beef;
      endcase
   endfunction

   // Drain this cycle's expectations on the falling edge, then step past the next rising edge.
   task automatic tick();
      @(negedge clk);
      while (exp_q.size() > 0) begin
         check_eq(tag_q.pop_front(), observe(kind_q.pop_front()), exp_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h1000_0010;
   localparam logic [31:0] A2 = 32'h1000_0020;

   initial begin
      rst_n = 1'b0; req = '0; panic = '0; excl = '0; hwrite = '0;
      hready = 1'b1; hresp = 1'b1; hexokay = 1'b0; hrdata = 32'h0bad_f00d;
      for (int k = 0; k < int'(NP); k++) begin
         haddr[k*WA +: WA] = A0 + 32'(k * 16);
         hsize[k*3 +: 3]   = 3'd2;
         hprot[k*4 +: 4]   = 4'b0011;
         wdata[k*WD +: WD] = 32'hA5A5_0000 + 32'(k);
      end
      @(posedge clk);
      #1;

      expect_val("rst_htrans", KTrans, 32'd0);
      expect_val("rst_haddr", KAddr, 32'd0);
      expect_val("rst_dph_rdy", KDph, 32'd0);
      expect_val("rst_dph_err", KErr, 32'd0);
      expect_val("rst_aph_rdy", KAph, 32'd0);
      tick();

      // Rotation with all sources requesting
      rst_n = 1'b1; hresp = 1'b0; req = 3'b111;
      expect_val("rr0_aph", KAph, 32'b001);
      expect_val("rr0_addr", KAddr, A0);
      expect_val("rr0_trans", KTrans, 32'd2);
      expect_val("rr0_dph", KDph, 32'b000);
      expect_val("rr0_fx_aph", KFxAph, 32'b001);
      tick();
      expect_val("rr1_aph", KAph, 32'b010);
      expect_val("rr1_addr", KAddr, A1);
      expect_val("rr1_dph", KDph, 32'b001);
      expect_val("rr1_fx_aph", KFxAph, 32'b001);
      tick();
      expect_val("rr2_aph", KAph, 32'b100);
      expect_val("rr2_addr", KAddr, A2);
      expect_val("rr2_dph", KDph, 32'b010);
      tick();
      expect_val("rr3_aph", KAph, 32'b001);
      expect_val("rr3_dph", KDph, 32'b100);
      expect_val("rr3_fx_aph", KFxAph, 32'b001);
      tick();

      // Source 1 stalled for three cycles; panic from source 0 waits for the hold to drop
      hready = 1'b0;
      expect_val("hold0_addr", KAddr, A1);
      expect_val("hold0_aph", KAph, 32'b000);
      expect_val("hold0_trans", KTrans, 32'd2);
      tick();
      panic = 3'b001;
      expect_val("hold1_addr", KAddr, A1);
      tick();
      expect_val("hold2_addr", KAddr, A1);
      tick();
      hready = 1'b1;
      expect_val("hold3_addr", KAddr, A1);
      expect_val("hold3_aph", KAph, 32'b010);
      tick();
      expect_val("panic_aph", KAph, 32'b001);
      expect_val("panic_addr", KAddr, A0);
      expect_val("panic_dph", KDph, 32'b010);
      tick();

      // Write by source 2, then read by source 0
      panic = '0; req = 3'b100; hwrite = 3'b100;
      expect_val("wr_aph", KAph, 32'b100);
      expect_val("wr_hwrite", KWrite, 32'd1);
      expect_val("wr_prev_dph", KDph, 32'b001);
      expect_val("wr_prev_wdata", KWdata, 32'hA5A5_0000);
      tick();
      req = 3'b001; hwrite = 3'b000;
      expect_val("rd_aph", KAph, 32'b001);
      expect_val("rd_hwrite", KWrite, 32'd0);
      expect_val("wr_dph_wdata", KWdata, 32'hA5A5_0002);
      expect_val("wr_dph_rdy", KDph, 32'b100);
      tick();

      // Two-cycle error response in source 1's data phase
      req = 3'b010;
      expect_val("err_aph", KAph, 32'b010);
      expect_val("err_prev_dph", KDph, 32'b001);
      tick();
      req = 3'b000; hready = 1'b0; hresp = 1'b1;
      expect_val("err0_trans", KTrans, 32'd0);
      expect_val("err0_addr", KAddr, 32'd0);
      expect_val("err0_err", KErr, 32'b010);
      expect_val("err0_dph", KDph, 32'b000);
      tick();
      hready = 1'b1; hexokay = 1'b1;
      expect_val("err1_err", KErr, 32'b010);
      expect_val("err1_dph", KDph, 32'b010);
      expect_val("err1_exok", KExok, 32'b010);
      tick();
      expect_val("err2_err", KErr, 32'b000);
      expect_val("err2_exok", KExok, 32'b000);
      expect_val("err2_dph", KDph, 32'b000);
      tick();

      // Sources 1 and 2 contend: fixed priority always picks 1, rotating alternates
      hresp = 1'b0; hexokay = 1'b0; req = 3'b110;
      for (int c = 0; c < 4; c++) begin
         expect_val($sformatf("fx_c%0d_aph", c), KFxAph, 32'b010);
         expect_val($sformatf("alt_c%0d_aph", c), KAph, (c % 2 == 0) ? 32'b100 : 32'b010);
         tick();
      end

      // Reset in the middle of source 1's stalled data phase
      req = 3'b111; hready = 1'b0; hresp = 1'b1; hexokay = 1'b1;
      expect_val("pre_rst_addr", KAddr, A2);
      expect_val("pre_rst_err", KErr, 32'b010);
      expect_val("pre_rst_exok", KExok, 32'b010);
      tick();
      hready = 1'b1;
      #1;
      rst_n = 1'b0;
      expect_val("in_rst_err", KErr, 32'b000);
      expect_val("in_rst_exok", KExok, 32'b000);
      expect_val("in_rst_dph", KDph, 32'b000);
      tick();
      req = '0; hresp = 1'b0; hexokay = 1'b0;
      expect_val("in_rst_idle", KTrans, 32'd0);
      tick();
      rst_n = 1'b1; req = 3'b111;
      expect_val("post_rst_aph", KAph, 32'b001);
      expect_val("post_rst_fx_aph", KFxAph, 32'b001);
      expect_val("post_rst_dph", KDph, 32'b000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
